alu_exec: RTL and testbench



---
 rtl/alu_pkg.sv | 11 +
 rtl/alu_multiplier.sv | 42 ++++
 rtl/alu_exec.sv | 57 +++++
 tb/tb_alu_exec.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU control codes and execution-stage FSM states
package alu_pkg;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_MUL = 4'b0011;
  typedef logic [0:0] state_t;
  localparam state_t S_IDLE = 1'b0;
  localparam state_t S_MUL  = 1'b1;
endpackage

// File: rtl/alu_multiplier.sv
// alu_multiplier: iterative shift-add multiplier, one multiplier bit per cycle, built only with ALU_EXEC_MUL_EN
`ifdef ALU_EXEC_MUL_EN
module alu_multiplier #(parameter int WIDTH = 64) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] p
);
  localparam int CW = $clog2(WIDTH);
  logic             busy;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mcand, mplier, acc_next;
  always_comb acc_next = mplier[0] ? p + mcand : p;
  always_ff @(posedge clk)
    if (rst) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      cnt    <= '0;
      p      <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else begin
      done <= busy && cnt == CW'(WIDTH-1);
      if (start) begin
        busy   <= 1'b1;
        cnt    <= '0;
        p      <= '0;
        mcand  <= a;
        mplier <= b;
      end else if (busy) begin
        p      <= acc_next;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        busy   <= cnt != CW'(WIDTH-1);
      end
    end
endmodule
`endif

// File: rtl/alu_exec.sv
// alu_exec: handshaked registered ALU stage; iterative MUL built only with ALU_EXEC_MUL_EN
module alu_exec import alu_pkg::*; #(parameter int WIDTH = 64) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inValid,
  output logic             inReady,
  input  logic [3:0]       aluControl,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] result,
  output logic             zero
);
  logic             busy, accept, is_mul, mul_done;
  logic [WIDTH-1:0] op_res, mul_p;
  always_comb begin
    inReady = !busy && (!outValid || outReady);
    accept  = inValid && inReady;
    op_res  = aluControl == ALU_AND ? operandA & operandB :
              aluControl == ALU_OR  ? operandA | operandB :
              aluControl == ALU_ADD ? operandA + operandB :
              aluControl == ALU_SUB ? operandA - operandB : '0;
    zero    = ~|result;
  end
`ifdef ALU_EXEC_MUL_EN
  state_t state;
  assign is_mul = aluControl == ALU_MUL;
  assign busy   = state == S_MUL;
  always_ff @(posedge clock)
    if (reset) state <= S_IDLE;
    else if (accept && is_mul) state <= S_MUL;
    else if (mul_done) state <= S_IDLE;
  alu_multiplier #(.WIDTH(WIDTH)) u_mul (
    .clk   (clock),
    .rst   (reset),
    .start (accept && is_mul),
    .a     (operandA),
    .b     (operandB),
    .done  (mul_done),
    .p     (mul_p)
  );
`else
  assign is_mul   = 1'b0;
  assign busy     = 1'b0;
  assign mul_done = 1'b0;
  assign mul_p    = '0;
`endif
  always_ff @(posedge clock)
    if (reset) begin
      outValid <= 1'b0;
      result   <= '0;
    end else begin
      outValid <= (accept && !is_mul) || mul_done || (outValid && !outReady);
      result   <= accept && !is_mul ? op_res : mul_done ? mul_p : result;
    end
endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: directed and randomized self-checking bench for alu_exec
module tb_alu_exec;
  localparam int W = 64;
  logic         clock = 1'b0;
  logic         reset, inValid, inReady, outValid, outReady, zero;
  logic [3:0]   aluControl;
  logic [W-1:0] operandA, operandB, result;
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] exp_q[$];

  alu_exec #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .inValid(inValid), .inReady(inReady),
    .aluControl(aluControl), .operandA(operandA), .operandB(operandB),
    .outValid(outValid), .outReady(outReady), .result(result), .zero(zero)
  );

  always #5 clock = ~clock;

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [W-1:0] model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
`ifdef ALU_EXEC_MUL_EN
      4'b0011: return a * b;
`endif
      default: return '0;
    endcase
  endfunction

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input bit v, input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    inValid = v;
    aluControl = c;
    operandA = a;
    operandB = b;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    outReady = 1'b0;
    drive(0, 4'h0, '0, '0);
    step;
    step;
    reset = 1'b0;
    step;
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL reset_outValid got %b want 0", outValid); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero got %b want 1", zero); end
    checks++; if (result !== '0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
    checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL reset_inReady got %b want 1", inReady); end
  endtask

  task automatic test_back_to_back;
    logic [3:0]   c[4]    = '{4'h2, 4'h6, 4'h0, 4'h1};
    logic [W-1:0] a[4]    = '{64'd5, 64'd3, 64'hF0, 64'h1};
    logic [W-1:0] b[4]    = '{64'd7, 64'd3, 64'h3C, 64'h2};
    logic [W-1:0] want[4] = '{64'd12, 64'd0, 64'h30, 64'h3};
    outReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1, c[i], a[i], b[i]);
      #1;
      checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL b2b_inReady[%0d] got %b want 1", i, inReady); end
      step;
      checks++; if (outValid !== 1'b1 || result !== want[i] || zero !== (want[i] == 0))
        begin errors++; $display("FAIL b2b_result[%0d] got v=%b r=%h z=%b want v=1 r=%h z=%b", i, outValid, result, zero, want[i], want[i] == 0); end
    end
    drive(0, 4'h0, '0, '0);
    step;
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b want 0", outValid); end
  endtask

  task automatic test_boundary;
    outReady = 1'b1;
    drive(1, 4'b0110, 64'd0, 64'd1);
    step;
    checks++; if (result !== 64'hFFFF_FFFF_FFFF_FFFF || zero !== 1'b0)
      begin errors++; $display("FAIL sub_wrap got r=%h z=%b want r=ffffffffffffffff z=0", result, zero); end
    drive(1, 4'b1111, {$urandom, $urandom}, {$urandom, $urandom});
    step;
    checks++; if (outValid !== 1'b1 || result !== '0 || zero !== 1'b1)
      begin errors++; $display("FAIL unknown_code got v=%b r=%h z=%b want v=1 r=0 z=1", outValid, result, zero); end
`ifndef ALU_EXEC_MUL_EN
    drive(1, 4'b0011, 64'd6, 64'd7);
    step;
    checks++; if (outValid !== 1'b1 || result !== '0 || zero !== 1'b1)
      begin errors++; $display("FAIL mul_disabled got v=%b r=%h z=%b want v=1 r=0 z=1", outValid, result, zero); end
`endif
    drive(0, 4'h0, '0, '0);
    step;
  endtask

  task automatic test_backpressure;
    outReady = 1'b0;
    drive(1, 4'b0010, 64'd2, 64'd2);
    step;
    drive(1, 4'b0001, 64'hA, 64'h5);
    for (int k = 0; k < 3; k++) begin
      checks++; if (outValid !== 1'b1 || result !== 64'd4 || zero !== 1'b0 || inReady !== 1'b0)
        begin errors++; $display("FAIL stall[%0d] got v=%b r=%h z=%b rdy=%b want v=1 r=4 z=0 rdy=0", k, outValid, result, zero, inReady); end
      step;
    end
    outReady = 1'b1;
    #1;
    checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL release_inReady got %b want 1", inReady); end
    step;
    checks++; if (outValid !== 1'b1 || result !== 64'hF)
      begin errors++; $display("FAIL release_next got v=%b r=%h want v=1 r=f", outValid, result); end
    drive(0, 4'h0, '0, '0);
    step;
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL release_drain got %b want 0", outValid); end
  endtask

`ifdef ALU_EXEC_MUL_EN
  task automatic test_mul;
    int n = 0;
    bit rdy_seen = 0;
    outReady = 1'b1;
    drive(1, 4'b0011, 64'd6, 64'd7);
    step;
    drive(0, 4'h0, '0, '0);
    while (!outValid && n < W + 10) begin
      if (inReady !== 1'b0) rdy_seen = 1;
      step;
      n++;
    end
    checks++; if (n != W + 1) begin errors++; $display("FAIL mul_latency got %0d want %0d", n, W + 1); end
    checks++; if (rdy_seen) begin errors++; $display("FAIL mul_inReady got 1 during multiply want 0"); end
    checks++; if (result !== 64'd42 || zero !== 1'b0)
      begin errors++; $display("FAIL mul_result got r=%h z=%b want r=2a z=0", result, zero); end
    step;
    checks++; if (outValid !== 1'b0 || inReady !== 1'b1)
      begin errors++; $display("FAIL mul_consume got v=%b rdy=%b want v=0 rdy=1", outValid, inReady); end
  endtask

  task automatic test_mul_reset;
    bit leak = 0;
    outReady = 1'b1;
    drive(1, 4'b0011, 64'd123, 64'd456);
    step;
    drive(0, 4'h0, '0, '0);
    repeat (5) step;
    reset = 1'b1;
    step;
    reset = 1'b0;
    checks++; if (outValid !== 1'b0 || inReady !== 1'b1)
      begin errors++; $display("FAIL mul_abort got v=%b rdy=%b want v=0 rdy=1", outValid, inReady); end
    repeat (W + 5) begin
      step;
      if (outValid !== 1'b0) leak = 1;
    end
    checks++; if (leak) begin errors++; $display("FAIL mul_abort_leak got outValid=1 after reset want 0"); end
  endtask
`endif

  task automatic test_random;
    logic [3:0]   codes[5] = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h3};
    logic [3:0]   c;
    logic [W-1:0] a, b, e;
    int           budget;
    for (int i = 0; i < 400; i++) begin
      c = $urandom_range(0, 5) == 5 ? 4'($urandom_range(0, 15)) : codes[$urandom_range(0, 4)];
      a = {$urandom, $urandom};
      b = $urandom_range(0, 7) == 0 ? a : {$urandom, $urandom};
      drive($urandom_range(0, 9) < 7, c, a, b);
      outReady = $urandom_range(0, 9) < 7;
      #1;
      if (outValid && outReady) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL rand_extra got r=%h want no output", result); end
        else begin
          e = exp_q.pop_front();
          if (result !== e || zero !== (e == 0))
            begin errors++; $display("FAIL rand_result got r=%h z=%b want r=%h z=%b", result, zero, e, e == 0); end
        end
      end
      if (inValid && inReady) exp_q.push_back(model(c, a, b));
      step;
    end
    drive(0, 4'h0, '0, '0);
    outReady = 1'b1;
    budget = 0;
    while (exp_q.size() != 0 && budget < 4 * W) begin
      #1;
      if (outValid) begin
        e = exp_q.pop_front();
        checks++; if (result !== e || zero !== (e == 0))
          begin errors++; $display("FAIL rand_drain got r=%h z=%b want r=%h z=%b", result, zero, e, e == 0); end
      end
      step;
      budget++;
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_pending got %0d outstanding want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset;
    test_back_to_back;
    test_boundary;
    test_backpressure;
`ifdef ALU_EXEC_MUL_EN
    test_mul;
    test_mul_reset;
`endif
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
